// File: rtl/sine_voice_scheduler_pkg.sv
// Shared widths, FSM encoding, lookup tag layout and a constant clog2 for the sine voice scheduler.
// Pure declarations: no logic, no latency, no flow control.
package sine_voice_scheduler_pkg;
  localparam int PHASE_W  = 16;
  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic vld;
    logic en;
  } tag_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/sine_voice_scheduler_if.sv
// Control, sine-pipeline and mix-output bundle of the scheduler; slave = scheduler, master = its environment.
// o_overrun_cnt exists only when SINE_VOICE_SCHED_OVERRUN_CNT_EN is defined.
interface sine_voice_scheduler_if #(parameter int NUM_VOICES = 8);
  import sine_voice_scheduler_pkg::*;

  localparam int VW    = clog2(NUM_VOICES);
  localparam int MIX_W = SAMPLE_W + VW;

  logic                       i_sample_tick;
  logic [NUM_VOICES-1:0]      i_voice_en;
  logic                       i_wr_en;
  logic [VW-1:0]              i_wr_voice;
  logic [PHASE_W-1:0]         i_wr_incr;
  logic [PHASE_W-1:0]         o_sine_phase;
  logic signed [SAMPLE_W-1:0] i_sine_val;
  logic signed [MIX_W-1:0]    o_mix;
  logic                       o_mix_valid;
  logic                       o_busy;
`ifdef SINE_VOICE_SCHED_OVERRUN_CNT_EN
  logic [7:0]                 o_overrun_cnt;
`endif

  modport slave (
    input  i_sample_tick, i_voice_en, i_wr_en, i_wr_voice, i_wr_incr, i_sine_val,
    output o_sine_phase, o_mix, o_mix_valid, o_busy
`ifdef SINE_VOICE_SCHED_OVERRUN_CNT_EN
    , output o_overrun_cnt
`endif
  );

  modport master (
    output i_sample_tick, i_voice_en, i_wr_en, i_wr_voice, i_wr_incr, i_sine_val,
    input  o_sine_phase, o_mix, o_mix_valid, o_busy
`ifdef SINE_VOICE_SCHED_OVERRUN_CNT_EN
    , input o_overrun_cnt
`endif
  );
endinterface

// File: rtl/sine_voice_scheduler_phase_bank.sv
// voice_phase_bank: per-voice increment and phase registers; write port plus read-and-advance port.
// Read is combinational, advance lands on the next edge; no flow control (writes accepted every cycle).
module voice_phase_bank
  import sine_voice_scheduler_pkg::*;
#(
  parameter  int NUM_VOICES = 8,
  localparam int VW         = clog2(NUM_VOICES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [VW-1:0]      wr_voice,
  input  logic [PHASE_W-1:0] wr_incr,
  input  logic [VW-1:0]      rd_voice,
  input  logic               adv,
  output logic [PHASE_W-1:0] rd_phase
);
  logic [PHASE_W-1:0] incr_q  [NUM_VOICES];
  logic [PHASE_W-1:0] incr_d  [NUM_VOICES];
  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [PHASE_W-1:0] phase_d [NUM_VOICES];

  // The advance reads incr_q, so a same-cycle write to this voice only counts next frame.
  always_comb begin
    incr_d  = incr_q;
    phase_d = phase_q;
    if (adv) phase_d[rd_voice] = phase_q[rd_voice] + incr_q[rd_voice];
    if (wr_en) incr_d[wr_voice] = wr_incr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      incr_q  <= '{default: '0};
      phase_q <= '{default: '0};
    end else begin
      incr_q  <= incr_d;
      phase_q <= phase_d;
    end
  end

  assign rd_phase = phase_q[rd_voice];
endmodule

// File: rtl/sine_voice_scheduler.sv
// Advances NUM_VOICES phases per frame, shares one sine pipeline, sums a mix; o_mix_valid NUM_VOICES+SINE_LATENCY+2 edges after the tick edge.
// No backpressure: ticks while o_busy are dropped (counted on o_overrun_cnt with SINE_VOICE_SCHED_OVERRUN_CNT_EN).
module sine_voice_scheduler
  import sine_voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES   = 8,
  parameter int SINE_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sine_voice_scheduler_if.slave bus
);
  localparam int VW    = clog2(NUM_VOICES);
  localparam int MIX_W = SAMPLE_W + VW;
  localparam int TAG_D = SINE_LATENCY + 1;

  state_t                  state_q, state_d;
  logic [VW-1:0]           voice_q, voice_d;
  logic signed [MIX_W-1:0] acc_q, acc_d, mix_q, mix_d;
  logic                    mix_valid_q, mix_valid_d;
  logic [PHASE_W-1:0]      sine_phase_q, sine_phase_d, bank_phase;
  tag_t                    tag_q [TAG_D];
  tag_t                    tag_d [TAG_D];
  tag_t                    tag_out;
  logic                    issue, adv, more_tags;

  assign issue   = (state_q == ISSUE);
  assign adv     = issue & bus.i_voice_en[voice_q];
  assign tag_out = tag_q[TAG_D-1];

  voice_phase_bank #(.NUM_VOICES(NUM_VOICES)) u_bank (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (bus.i_wr_en),
    .wr_voice (bus.i_wr_voice),
    .wr_incr  (bus.i_wr_incr),
    .rd_voice (voice_q),
    .adv      (adv),
    .rd_phase (bank_phase)
  );

  always_comb begin
    state_d      = state_q;
    voice_d      = voice_q;
    acc_d        = acc_q;
    mix_d        = mix_q;
    mix_valid_d  = 1'b0;
    sine_phase_d = sine_phase_q;
    more_tags    = 1'b0;

    // The tag reaches the last stage in the same cycle its sample sits on i_sine_val.
    tag_d[0].vld = issue;
    tag_d[0].en  = adv;
    for (int i = 1; i < TAG_D; i++) tag_d[i] = tag_q[i-1];
    for (int i = 0; i < TAG_D-1; i++) more_tags = more_tags | tag_q[i].vld;

    if (tag_out.vld && tag_out.en) acc_d = acc_q + MIX_W'(bus.i_sine_val);

    case (state_q)
      IDLE: begin
        if (bus.i_sample_tick) begin
          state_d = ISSUE;
          voice_d = '0;
          acc_d   = '0;
        end
      end
      ISSUE: begin
        sine_phase_d = bank_phase;
        voice_d      = voice_q + 1'b1;
        if (voice_q == VW'(NUM_VOICES-1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (tag_out.vld && !more_tags) state_d = DONE;
      end
      DONE: begin
        mix_d       = acc_q;
        mix_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      voice_q      <= '0;
      acc_q        <= '0;
      mix_q        <= '0;
      mix_valid_q  <= 1'b0;
      sine_phase_q <= '0;
      tag_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      voice_q      <= voice_d;
      acc_q        <= acc_d;
      mix_q        <= mix_d;
      mix_valid_q  <= mix_valid_d;
      sine_phase_q <= sine_phase_d;
      tag_q        <= tag_d;
    end
  end

  assign bus.o_sine_phase = sine_phase_q;
  assign bus.o_mix        = mix_q;
  assign bus.o_mix_valid  = mix_valid_q;
  // Busy covers the strobe cycle, yet a tick in that cycle finds IDLE and is accepted.
  assign bus.o_busy       = (state_q != IDLE) | mix_valid_q;

`ifdef SINE_VOICE_SCHED_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt_q, overrun_cnt_d;

  always_comb begin
    overrun_cnt_d = overrun_cnt_q;
    if (bus.i_sample_tick && (state_q != IDLE) && (overrun_cnt_q != 8'hFF))
      overrun_cnt_d = overrun_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overrun_cnt_q <= '0;
    else          overrun_cnt_q <= overrun_cnt_d;
  end

  assign bus.o_overrun_cnt = overrun_cnt_q;
`endif
endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Scoreboard bench: a frame-level reference model queues expected phases, mixes and busy windows;
// a negedge monitor compares them against the scheduler driven by a 3-stage sine pipeline model.
module tb_sine_voice_scheduler;
  import sine_voice_scheduler_pkg::*;

  localparam int NV = 8;
  localparam int SL = 3;
  localparam int VW = clog2(NV);
  localparam int FRAME = 1 + NV + SL + 2;

  typedef struct { int cyc; logic [15:0] ph; } ph_e;
  typedef struct { int cyc; int mix; int ovr; } mix_e;

  logic clk;
  logic reset_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [15:0]        ph_m   [NV];
  logic [15:0]        incr_m [NV];
  logic [NV-1:0]      en_m;
  bit                 const_mode = 1'b0;
  logic signed [15:0] const_val  = '0;
  int                 ovr_m = 0;

  ph_e  phq[$];
  mix_e mixq[$];
  int   busyq[$];
  ph_e  pe_mon;
  mix_e me_mon;
  bit   exp_busy;

  sine_voice_scheduler_if #(.NUM_VOICES(NV)) bus ();

  sine_voice_scheduler #(.NUM_VOICES(NV), .SINE_LATENCY(SL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Triangle stand-in for the sine: 0 at 0x0000, +32767 at 0x4000, 0 at 0x8000, -32767 at 0xC000.
  function automatic logic signed [15:0] sine_model(input logic [15:0] ph);
    int f;
    logic signed [15:0] r;
    f = int'(ph[13:0]) * 2;
    case (ph[15:14])
      2'd0:    r = 16'(f);
      2'd1:    r = 16'(32767 - f);
      2'd2:    r = 16'(-f);
      default: r = 16'(-32767 + f);
    endcase
    if (const_mode) r = const_val;
    return r;
  endfunction

  logic signed [15:0] s1 = '0, s2 = '0, s3 = '0;
  always @(posedge clk) begin
    s1 <= sine_model(bus.o_sine_phase);
    s2 <= s1;
    s3 <= s2;
  end
  assign bus.i_sine_val = s3;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Whole-frame reference: voice v's phase appears in cycle c+v+2; a write driven at offset
  // wr_off reaches voice v's advance only if it is sampled strictly before that advance edge.
  task automatic model_frame(input int c, input int wr_off, input int wv, input logic [15:0] wi,
                             input int ovr_off);
    int mix;
    logic [15:0] inc;
    ph_e pe;
    mix_e me;
    mix = 0;
    for (int v = 0; v < NV; v++) begin
      pe.cyc = c + v + 2;
      pe.ph  = ph_m[v];
      phq.push_back(pe);
      inc = incr_m[v];
      if (wr_off >= 0 && v == wv && wr_off < v + 1) inc = wi;
      if (en_m[v]) begin
        mix     = mix + int'(sine_model(ph_m[v]));
        ph_m[v] = ph_m[v] + inc;
      end
    end
    if (wr_off >= 0) incr_m[wv] = wi;
    if (ovr_off > 0 && ovr_m < 255) ovr_m++;
    me.cyc = c + FRAME;
    me.mix = mix;
    me.ovr = ovr_m;
    mixq.push_back(me);
    busyq.push_back(c);
  endtask

  // Tick at offset 0; optional write at wr_off and dropped tick at ovr_off; tail idle cycles after.
  task automatic do_frame(input int wr_off, input int wv, input logic [15:0] wi,
                          input int ovr_off, input int tail);
    int c;
    c = cyc;
    bus.i_voice_en = en_m;
    model_frame(c, wr_off, wv, wi, ovr_off);
    for (int o = 0; o < FRAME + tail; o++) begin
      bus.i_sample_tick = (o == 0) || (ovr_off > 0 && o == ovr_off);
      bus.i_wr_en       = (wr_off >= 0 && o == wr_off);
      bus.i_wr_voice    = wv[VW-1:0];
      bus.i_wr_incr     = wi;
      @(posedge clk); #1;
    end
    bus.i_sample_tick = 1'b0;
    bus.i_wr_en       = 1'b0;
  endtask

  task automatic idle_write(input int v, input logic [15:0] val);
    bus.i_wr_en    = 1'b1;
    bus.i_wr_voice = v[VW-1:0];
    bus.i_wr_incr  = val;
    @(posedge clk); #1;
    bus.i_wr_en = 1'b0;
    incr_m[v]   = val;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_sine_phase"}, bus.o_sine_phase, 0);
    chk({tag, "_mix"}, bus.o_mix, 0);
    chk({tag, "_mix_valid"}, bus.o_mix_valid, 0);
    chk({tag, "_busy"}, bus.o_busy, 0);
`ifdef SINE_VOICE_SCHED_OVERRUN_CNT_EN
    chk({tag, "_overrun_cnt"}, bus.o_overrun_cnt, 0);
`endif
  endtask

  always @(negedge clk) begin
    if (bus.o_mix_valid === 1'b1) begin
      if (mixq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_mix_valid at cycle %0d: got strobe (mix %0d), expected none", cyc, bus.o_mix);
      end else begin
        me_mon = mixq.pop_front();
        chk("mix_value", bus.o_mix, me_mon.mix);
        chk("mix_cycle", cyc, me_mon.cyc);
`ifdef SINE_VOICE_SCHED_OVERRUN_CNT_EN
        chk("overrun_cnt", bus.o_overrun_cnt, me_mon.ovr);
`endif
      end
    end
    if (mixq.size() > 0 && mixq[0].cyc < cyc) begin
      me_mon = mixq.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_mix_valid: got no strobe by cycle %0d, expected at cycle %0d", cyc, me_mon.cyc);
    end
    if (phq.size() > 0 && phq[0].cyc == cyc) begin
      pe_mon = phq.pop_front();
      chk("sine_phase", bus.o_sine_phase, pe_mon.ph);
    end
    while (busyq.size() > 0 && busyq[0] + FRAME < cyc) void'(busyq.pop_front());
    exp_busy = (busyq.size() > 0) && (busyq[0] + 1 <= cyc);
    chk("busy", bus.o_busy, exp_busy);
  end

  initial begin
    int c, wo, wvr, oo, tl;
    logic [15:0] wir;

    reset_n           = 1'b0;
    bus.i_sample_tick = 1'b0;
    bus.i_voice_en    = '0;
    bus.i_wr_en       = 1'b0;
    bus.i_wr_voice    = '0;
    bus.i_wr_incr     = '0;
    en_m              = '0;
    for (int v = 0; v < NV; v++) begin
      ph_m[v]   = '0;
      incr_m[v] = '0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // All voices on, zero increments: eight 0x0000 phases, zero mix, 13-cycle latency.
    en_m = '1;
    do_frame(-1, 0, 16'h0, 0, 2);

    // Voice 0 alone stepping a quarter turn per frame.
    idle_write(0, 16'h4000);
    en_m = 8'h01;
    repeat (3) do_frame(-1, 0, 16'h0, 0, 0);
    do_frame(-1, 0, 16'h0, 0, 2);

    // Phase wrap: 0 -> 0xFFFF -> 0xFFFE.
    idle_write(1, 16'hFFFF);
    en_m = 8'h02;
    repeat (3) do_frame(-1, 0, 16'h0, 0, 1);

    // Full-scale mixes.
    en_m       = '1;
    const_mode = 1'b1;
    const_val  = 16'sd32767;
    do_frame(-1, 0, 16'h0, 0, 0);
    const_val  = -16'sd32768;
    do_frame(-1, 0, 16'h0, 0, 2);
    const_mode = 1'b0;

    // Overruns: mid-frame and in the DONE cycle, then a tick coincident with the strobe.
    do_frame(-1, 0, 16'h0, 5, 2);
    do_frame(-1, 0, 16'h0, 13, 0);
    do_frame(-1, 0, 16'h0, 0, 2);

    // Increment write landing on voice 2's issue edge.
    idle_write(2, 16'h1000);
    do_frame(3, 2, 16'h2000, 0, 0);
    repeat (2) do_frame(-1, 0, 16'h0, 0, 1);

    for (int f = 0; f < 30; f++) begin
      en_m = NV'($urandom);
      wo   = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 15));
      wvr  = int'($urandom_range(0, NV - 1));
      wir  = 16'($urandom);
      oo   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 13)) : 0;
      tl   = int'($urandom_range(0, 3));
      if (wo > FRAME - 1 + tl) wo = FRAME - 1 + tl;
      do_frame(wo, wvr, wir, oo, tl);
    end

    // Make o_mix non-zero so the reset clearing it is visible.
    const_mode = 1'b1;
    const_val  = 16'sd1000;
    en_m       = '1;
    do_frame(-1, 0, 16'h0, 0, 1);
    const_mode = 1'b0;

    // Reset asserted in DRAIN: the frame is abandoned and must not strobe.
    bus.i_voice_en = en_m;
    c = cyc;
    model_frame(c, -1, 0, 16'h0, 0);
    bus.i_sample_tick = 1'b1;
    @(posedge clk); #1;
    bus.i_sample_tick = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    void'(mixq.pop_back());
    void'(busyq.pop_back());
    for (int v = 0; v < NV; v++) begin
      ph_m[v]   = '0;
      incr_m[v] = '0;
    end
    ovr_m = 0;
    @(negedge clk);
    check_outputs_zero("midframe_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    en_m = NV'($urandom);
    idle_write(3, 16'h0123);
    repeat (2) do_frame(-1, 0, 16'h0, 0, 3);

    repeat (5) @(posedge clk);
    while (mixq.size() > 0) begin
      me_mon = mixq.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL pending_mix: got no strobe, expected one at cycle %0d", me_mon.cyc);
    end
    while (phq.size() > 0) begin
      pe_mon = phq.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL pending_phase: got no check, expected phase %0d at cycle %0d", pe_mon.ph, pe_mon.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
